// File: rtl/hazard_flush_ctrl.sv
// Hazard and flush controller for the pipelined RAT core: RAW stall/forward detection,
// control-flow and interrupt flushes, and fetch/decode/PC steering.
module hazard_flush_ctrl #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned RET_CYCLES   = 3,
  parameter int unsigned RESET_CYCLES = 2,
  parameter bit          FWD_EN       = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_rd,
  input  logic [REG_AW-1:0]         ex_addr,
  input  logic                      ex_wen,
  input  logic [REG_AW-1:0]         wb_addr,
  input  logic                      wb_wen,
  input  logic [3:0]                instr_type,
  input  logic                      branch_taken,
  input  logic                      interrupt,
  output logic                      fetch_stall,
  output logic                      dec_nop,
  output logic                      pc_inc,
  output logic                      pc_load,
  output logic                      pc_reset,
  output logic [NUM_SRC-1:0]        fwd_wb,
  output logic                      int_ack,
  output logic                      busy
);

  localparam int unsigned MaxFR    = (FLUSH_CYCLES > RET_CYCLES) ? FLUSH_CYCLES : RET_CYCLES;
  localparam int unsigned MaxDepth = (MaxFR > RESET_CYCLES) ? MaxFR : RESET_CYCLES;
  localparam int unsigned CntW     = (MaxDepth > 8) ? $clog2(MaxDepth) : 3;

  localparam logic [CntW-1:0] FlushInit = CntW'(FLUSH_CYCLES - 1);
  localparam logic [CntW-1:0] RetInit   = CntW'(RET_CYCLES - 1);
  localparam logic [CntW-1:0] ResetInit = CntW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    StReset,
    StCheck,
    StRawStall,
    StFlush,
    StReturn
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              int_ack_q, int_ack_d;

  logic [NUM_SRC-1:0] raw_ex, raw_wb;
  logic               any_raw_ex, wb_stall, is_ret, is_call, in_check;

  always_comb begin
    raw_ex = '0;
    raw_wb = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      raw_ex[i] = src_rd[i] & ex_wen & (src_addr[i*REG_AW +: REG_AW] == ex_addr);
      raw_wb[i] = src_rd[i] & wb_wen & (src_addr[i*REG_AW +: REG_AW] == wb_addr);
    end
  end

  assign any_raw_ex = |raw_ex;
  assign wb_stall   = !FWD_EN && (|raw_wb);
  assign is_ret     = (instr_type == 4'd7) || (instr_type == 4'd8) || (instr_type == 4'd9);
  assign is_call    = (instr_type == 4'd6);
  assign in_check   = (state_q == StCheck);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    int_ack_d = 1'b0;
    pc_load   = 1'b0;
    dec_nop   = 1'b1;
    unique case (state_q)
      StCheck: begin
        // Interrupt wins outright: every other event this cycle is dropped.
        if (interrupt) begin
          state_d   = StFlush;
          cnt_d     = FlushInit;
          int_ack_d = 1'b1;
        end else if (any_raw_ex) begin
          state_d = StRawStall;
        end else if (is_call) begin
          state_d = StFlush;
          cnt_d   = FlushInit;
        end else if (is_ret) begin
          state_d = StReturn;
          cnt_d   = RetInit;
          pc_load = 1'b1;
        end else if (branch_taken) begin
          state_d = StFlush;
          cnt_d   = FlushInit;
          pc_load = 1'b1;
        end else if (!wb_stall) begin
          dec_nop = 1'b0;
        end
      end
      StRawStall: state_d = StCheck;
      StFlush, StReturn, StReset: begin
        if (cnt_q == '0) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StReset;
        cnt_d   = ResetInit;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StReset;
      cnt_q     <= ResetInit;
      int_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      int_ack_q <= int_ack_d;
    end
  end

  assign fetch_stall = (in_check && (any_raw_ex || wb_stall || is_ret) && !interrupt) ||
                       (state_q == StRawStall);
  assign pc_inc      = !reset && !pc_load && !fetch_stall;
  assign pc_reset    = reset;
  // The EX result is newer than WB, so an EX match suppresses the WB forward.
  assign fwd_wb      = (FWD_EN && in_check) ? (raw_wb & ~raw_ex) : '0;
  assign int_ack     = int_ack_q;
  assign busy        = !in_check;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl: one stalling instance and one forwarding instance
// share the same stimulus.
module tb_hazard_flush_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  src_addr;
  logic [1:0]  src_rd;
  logic [4:0]  ex_addr, wb_addr;
  logic        ex_wen, wb_wen;
  logic [3:0]  instr_type;
  logic        branch_taken, interrupt;

  logic       fetch_stall, dec_nop, pc_inc, pc_load, pc_reset, int_ack, busy;
  logic [1:0] fwd_wb;
  logic       f_fetch_stall, f_dec_nop, f_pc_inc, f_pc_load, f_pc_reset, f_int_ack, f_busy;
  logic [1:0] f_fwd_wb;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  hazard_flush_ctrl dut (
    .clk(clk), .reset(reset), .src_addr(src_addr), .src_rd(src_rd),
    .ex_addr(ex_addr), .ex_wen(ex_wen), .wb_addr(wb_addr), .wb_wen(wb_wen),
    .instr_type(instr_type), .branch_taken(branch_taken), .interrupt(interrupt),
    .fetch_stall(fetch_stall), .dec_nop(dec_nop), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_reset(pc_reset), .fwd_wb(fwd_wb), .int_ack(int_ack), .busy(busy)
  );

  hazard_flush_ctrl #(.FWD_EN(1'b1)) dut_fwd (
    .clk(clk), .reset(reset), .src_addr(src_addr), .src_rd(src_rd),
    .ex_addr(ex_addr), .ex_wen(ex_wen), .wb_addr(wb_addr), .wb_wen(wb_wen),
    .instr_type(instr_type), .branch_taken(branch_taken), .interrupt(interrupt),
    .fetch_stall(f_fetch_stall), .dec_nop(f_dec_nop), .pc_inc(f_pc_inc), .pc_load(f_pc_load),
    .pc_reset(f_pc_reset), .fwd_wb(f_fwd_wb), .int_ack(f_int_ack), .busy(f_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src_addr = '0; src_rd = '0; ex_addr = '0; ex_wen = 1'b0; wb_addr = '0; wb_wen = 1'b0;
    instr_type = 4'd0; branch_taken = 1'b0; interrupt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_dec_nop", dec_nop, 1);
    check("rst_pc_reset", pc_reset, 1);
    check("rst_pc_inc", pc_inc, 0);
    check("rst_pc_load", pc_load, 0);
    check("rst_fetch_stall", fetch_stall, 0);
    check("rst_int_ack", int_ack, 0);
    check("rst_fwd_wb", f_fwd_wb, 0);

    reset = 1'b0; #1;
    check("rel1_dec_nop", dec_nop, 1);
    check("rel1_pc_reset", pc_reset, 0);
    check("rel1_busy", busy, 1);
    tick();
    check("rel2_dec_nop", dec_nop, 1);
    tick();
    check("rel_done_dec_nop", dec_nop, 0);
    check("rel_done_pc_inc", pc_inc, 1);
    check("rel_done_busy", busy, 0);

    // Matching addresses but no read enable: no hazard.
    src_addr = {5'd0, 5'd5}; src_rd = 2'b00; ex_addr = 5'd5; ex_wen = 1'b1; #1;
    check("noread_stall", fetch_stall, 0);
    check("noread_pc_inc", pc_inc, 1);

    // RAW against EX on operand 0.
    src_rd = 2'b01; #1;
    check("rawex_stall", fetch_stall, 1);
    check("rawex_nop", dec_nop, 1);
    check("rawex_pc_inc", pc_inc, 0);
    tick();
    check("rawst_stall", fetch_stall, 1);
    check("rawst_nop", dec_nop, 1);
    check("rawst_busy", busy, 1);
    idle();
    tick();
    check("rawst_back", dec_nop, 0);
    check("rawst_back_inc", pc_inc, 1);

    // RAW against WB on operand 1: stall without forwarding, forward with it.
    src_addr = {5'd3, 5'd0}; src_rd = 2'b10; wb_addr = 5'd3; wb_wen = 1'b1; #1;
    check("wb_stall", fetch_stall, 1);
    check("wb_nop", dec_nop, 1);
    check("wb_pc_inc", pc_inc, 0);
    check("wb_fwd_off", fwd_wb, 2'b00);
    check("fwd_sel", f_fwd_wb, 2'b10);
    check("fwd_stall", f_fetch_stall, 0);
    check("fwd_nop", f_dec_nop, 0);
    check("fwd_pc_inc", f_pc_inc, 1);
    tick();
    check("wb_stall_hold", fetch_stall, 1);
    check("wb_stall_busy", busy, 0);
    // EX also matches: EX wins, forward dropped and EX stall taken.
    ex_addr = 5'd3; ex_wen = 1'b1; #1;
    check("fwd_ex_wins", f_fwd_wb, 2'b00);
    check("fwd_ex_stall", f_fetch_stall, 1);
    tick();
    idle();
    tick();
    check("fwd_ex_back", f_busy, 0);

    // Taken branch: load this cycle, then two flush cycles that ignore branches.
    branch_taken = 1'b1; #1;
    check("br_load", pc_load, 1);
    check("br_nop", dec_nop, 1);
    check("br_inc", pc_inc, 0);
    check("br_stall", fetch_stall, 0);
    tick();
    check("br_fl1_load", pc_load, 0);
    check("br_fl1_nop", dec_nop, 1);
    branch_taken = 1'b0;
    tick();
    check("br_fl2_nop", dec_nop, 1);
    tick();
    check("br_done_nop", dec_nop, 0);
    check("br_done_inc", pc_inc, 1);

    // Return variant 8: one load/stall cycle plus three return cycles.
    instr_type = 4'd8; #1;
    check("ret_load", pc_load, 1);
    check("ret_stall", fetch_stall, 1);
    check("ret_nop", dec_nop, 1);
    check("ret_inc", pc_inc, 0);
    tick();
    instr_type = 4'd0; #1;
    check("ret1_load", pc_load, 0);
    check("ret1_stall", fetch_stall, 0);
    check("ret1_nop", dec_nop, 1);
    tick();
    check("ret2_nop", dec_nop, 1);
    tick();
    check("ret3_nop", dec_nop, 1);
    tick();
    check("ret_done_nop", dec_nop, 0);
    check("ret_done_inc", pc_inc, 1);

    // Call: flush without a load.
    instr_type = 4'd6; #1;
    check("call_load", pc_load, 0);
    check("call_nop", dec_nop, 1);
    tick();
    instr_type = 4'd0;
    check("call_busy1", busy, 1);
    tick();
    check("call_busy2", busy, 1);
    tick();
    check("call_done", busy, 0);

    // Interrupt beats a concurrent branch and an EX hazard.
    interrupt = 1'b1; branch_taken = 1'b1;
    src_addr = {5'd0, 5'd9}; src_rd = 2'b01; ex_addr = 5'd9; ex_wen = 1'b1; #1;
    check("int_load", pc_load, 0);
    check("int_stall", fetch_stall, 0);
    check("int_nop", dec_nop, 1);
    check("int_ack0", int_ack, 0);
    check("int_busy0", busy, 0);
    tick();
    branch_taken = 1'b0; src_rd = 2'b00; ex_wen = 1'b0;
    check("int_ack1", int_ack, 1);
    check("int_busy1", busy, 1);
    tick();
    interrupt = 1'b0;
    check("int_ack2", int_ack, 0);
    check("int_busy2", busy, 1);
    tick();
    check("int_busy3", busy, 0);
    check("int_ack3", int_ack, 0);

    // Reset in the middle of a flush.
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    reset = 1'b1; #1;
    check("midrst_nop", dec_nop, 1);
    check("midrst_pc_reset", pc_reset, 1);
    check("midrst_inc", pc_inc, 0);
    check("midrst_load", pc_load, 0);
    tick();
    reset = 1'b0; #1;
    check("midrst_rel1", dec_nop, 1);
    tick();
    check("midrst_rel2", dec_nop, 1);
    tick();
    check("midrst_done_nop", dec_nop, 0);
    check("midrst_done_inc", pc_inc, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
